// File: rtl/apb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : apb_pkg                                                |
// | Brief   : Shared types and constants for the APB master bridge.  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package apb_pkg;

  // Bridge protocol phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Default bus geometry
  localparam int APB_AW = 9;
  localparam int APB_DW = 8;

  // Address bit that chooses between the two slaves
  localparam int SLV_SEL_BIT = APB_AW - 1;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_slave_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : apb_slave_decoder                                       |
// | Brief  : Address-MSB slave select decode and read-data mux.      |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module apb_slave_decoder #(
  parameter int DW = 8
) (
  input  logic          req_msb,  // slave bit of the address being accepted
  input  logic          act_msb,  // slave bit of the transfer in flight
  input  logic [DW-1:0] prdata1,
  input  logic [DW-1:0] prdata2,
  output logic          sel1,
  output logic          sel2,
  output logic [DW-1:0] prdata
);

  // Select exactly one slave and return only the active slave's read data
  always_comb begin
    sel1   = ~req_msb;
    sel2   = req_msb;
    prdata = act_msb ? prdata2 : prdata1;
  end

endmodule : apb_slave_decoder
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : apb_master_bridge                                       |
// | Brief  : Turns single-cycle user requests into APB SETUP/ACCESS  |
// |          transfers towards two slaves; returns rdata and error.  |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int AW = APB_AW,
  parameter int DW = APB_DW
) (
  input  logic          pclk,
  input  logic          presetn,
  // user request side
  input  logic          i_ptransfer,
  input  logic          i_pwrite,
  input  logic [AW-1:0] i_pwaddr,
  input  logic [DW-1:0] i_pwdata,
  input  logic [AW-1:0] i_praddr,
  output logic [DW-1:0] o_prdata,
  output logic          o_ready,
  output logic          o_slverr,
  // APB side
  output logic [AW-1:0] o_paddr,
  output logic          o_pwrite,
  output logic [DW-1:0] o_pwdata,
  output logic          o_psel1,
  output logic          o_psel2,
  output logic          o_penable,
  input  logic          i_pready,
  input  logic [DW-1:0] i_prdata1,
  input  logic [DW-1:0] i_prdata2,
  input  logic          i_pslverr
);

  localparam int SEL_BIT = AW - 1;

  apb_state_e    state;
  logic [AW-1:0] req_addr;
  logic          dec_sel1;
  logic          dec_sel2;
  logic [DW-1:0] mux_rdata;

  // Address of an incoming request depends on its direction
  always_comb begin
    req_addr = i_pwrite ? i_pwaddr : i_praddr;
  end

  apb_slave_decoder #(
    .DW (DW)
  ) u_decoder (
    .req_msb (req_addr[SEL_BIT]),
    .act_msb (o_paddr[SEL_BIT]),
    .prdata1 (i_prdata1),
    .prdata2 (i_prdata2),
    .sel1    (dec_sel1),
    .sel2    (dec_sel2),
    .prdata  (mux_rdata)
  );

  // Protocol FSM; every output is registered so selects are valid in SETUP
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      o_paddr   <= '0;
      o_pwrite  <= 1'b0;
      o_pwdata  <= '0;
      o_psel1   <= 1'b0;
      o_psel2   <= 1'b0;
      o_penable <= 1'b0;
      o_ready   <= 1'b1;
      o_slverr  <= 1'b0;
      o_prdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_ptransfer) begin
            state    <= SETUP;
            o_paddr  <= req_addr;
            o_pwrite <= i_pwrite;
            if (i_pwrite) begin
              o_pwdata <= i_pwdata;
            end
            o_psel1  <= dec_sel1;
            o_psel2  <= dec_sel2;
            o_ready  <= 1'b0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          o_penable <= 1'b1;
        end
        ACCESS: begin
          // Wait states simply hold everything until the slave is ready
          if (i_pready) begin
            state     <= IDLE;
            o_penable <= 1'b0;
            o_psel1   <= 1'b0;
            o_psel2   <= 1'b0;
            o_ready   <= 1'b1;
            o_slverr  <= i_pslverr;
            if (!o_pwrite) begin
              o_prdata <= mux_rdata;
            end
          end
        end
        default: begin
          state     <= IDLE;
          o_penable <= 1'b0;
          o_psel1   <= 1'b0;
          o_psel2   <= 1'b0;
          o_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule : apb_master_bridge
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_apb_master_bridge                                    |
// | Brief  : Directed self-checking bench for apb_master_bridge.     |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_apb_master_bridge;

  localparam int AW = 9;
  localparam int DW = 8;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          i_ptransfer;
  logic          i_pwrite;
  logic [AW-1:0] i_pwaddr;
  logic [DW-1:0] i_pwdata;
  logic [AW-1:0] i_praddr;
  logic [DW-1:0] o_prdata;
  logic          o_ready;
  logic          o_slverr;
  logic [AW-1:0] o_paddr;
  logic          o_pwrite;
  logic [DW-1:0] o_pwdata;
  logic          o_psel1;
  logic          o_psel2;
  logic          o_penable;
  logic          i_pready;
  logic [DW-1:0] i_prdata1;
  logic [DW-1:0] i_prdata2;
  logic          i_pslverr;

  int errors = 0;
  int checks = 0;

  apb_master_bridge #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .i_ptransfer (i_ptransfer),
    .i_pwrite    (i_pwrite),
    .i_pwaddr    (i_pwaddr),
    .i_pwdata    (i_pwdata),
    .i_praddr    (i_praddr),
    .o_prdata    (o_prdata),
    .o_ready     (o_ready),
    .o_slverr    (o_slverr),
    .o_paddr     (o_paddr),
    .o_pwrite    (o_pwrite),
    .o_pwdata    (o_pwdata),
    .o_psel1     (o_psel1),
    .o_psel2     (o_psel2),
    .o_penable   (o_penable),
    .i_pready    (i_pready),
    .i_prdata1   (i_prdata1),
    .i_prdata2   (i_prdata2),
    .i_pslverr   (i_pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, settle just after the edge, and check select exclusivity
  task automatic tick();
    @(posedge pclk);
    #1;
    check("sel_excl", {31'd0, o_psel1 & o_psel2}, 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    check({tag, "_en"},    {31'd0, o_penable}, 32'd0);
    check({tag, "_sel"},   {30'd0, o_psel1, o_psel2}, 32'd0);
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_paddr"}, {23'd0, o_paddr}, 32'd0);
    check({tag, "_pwdata"}, {24'd0, o_pwdata}, 32'd0);
    check({tag, "_pwrite"}, {31'd0, o_pwrite}, 32'd0);
    check({tag, "_prdata"}, {24'd0, o_prdata}, 32'd0);
    check({tag, "_slverr"}, {31'd0, o_slverr}, 32'd0);
    check_idle(tag);
  endtask

  initial begin
    presetn = 1'b0;
    i_ptransfer = 0; i_pwrite = 0; i_pwaddr = '0; i_pwdata = '0; i_praddr = '0;
    i_pready = 0; i_prdata1 = '0; i_prdata2 = '0; i_pslverr = 0;

    // Reset with random inputs for three cycles
    for (int i = 0; i < 3; i++) begin
      i_ptransfer = 1'($urandom); i_pwrite = 1'($urandom);
      i_pwaddr = 9'($urandom); i_pwdata = 8'($urandom); i_praddr = 9'($urandom);
      i_pready = 1'($urandom); i_prdata1 = 8'($urandom); i_prdata2 = 8'($urandom);
      i_pslverr = 1'($urandom);
      tick();
      check_all_reset("rst");
    end
    i_ptransfer = 0; i_pready = 0; i_pslverr = 0;
    presetn = 1'b1;
    tick();
    check_all_reset("post_rst");

    // Write slave1, no wait states
    i_ptransfer = 1; i_pwrite = 1; i_pwaddr = 9'h012; i_pwdata = 8'hA5;
    i_praddr = 9'h1EE; i_pready = 1; i_pslverr = 0;
    tick();
    i_ptransfer = 0;
    check("w1_setup_sel1", {31'd0, o_psel1}, 32'd1);
    check("w1_setup_sel2", {31'd0, o_psel2}, 32'd0);
    check("w1_setup_en", {31'd0, o_penable}, 32'd0);
    check("w1_setup_addr", {23'd0, o_paddr}, 32'h012);
    check("w1_setup_ready", {31'd0, o_ready}, 32'd0);
    check("w1_setup_pwrite", {31'd0, o_pwrite}, 32'd1);
    tick();
    check("w1_acc_en", {31'd0, o_penable}, 32'd1);
    check("w1_acc_sel1", {31'd0, o_psel1}, 32'd1);
    check("w1_acc_wdata", {24'd0, o_pwdata}, 32'hA5);
    tick();
    check_idle("w1_done");
    check("w1_slverr", {31'd0, o_slverr}, 32'd0);
    check("w1_prdata", {24'd0, o_prdata}, 32'd0);

    // Read slave2 with two wait states
    i_ptransfer = 1; i_pwrite = 0; i_praddr = 9'h105; i_pwaddr = 9'h0AA;
    i_pwdata = 8'h11; i_pready = 0; i_prdata1 = 8'h11; i_prdata2 = 8'h3C;
    tick();
    i_ptransfer = 0;
    check("r2_setup_sel2", {31'd0, o_psel2}, 32'd1);
    check("r2_setup_addr", {23'd0, o_paddr}, 32'h105);
    check("r2_setup_pwrite", {31'd0, o_pwrite}, 32'd0);
    check("r2_setup_wdata_hold", {24'd0, o_pwdata}, 32'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r2_acc_en", {31'd0, o_penable}, 32'd1);
      check("r2_acc_sel2", {31'd0, o_psel2}, 32'd1);
      check("r2_acc_ready", {31'd0, o_ready}, 32'd0);
      check("r2_acc_prdata_hold", {24'd0, o_prdata}, 32'd0);
    end
    i_pready = 1;
    tick();
    check_idle("r2_done");
    check("r2_prdata", {24'd0, o_prdata}, 32'h3C);

    // Error response on a write, then cleared by a clean read of slave1
    i_ptransfer = 1; i_pwrite = 1; i_pwaddr = 9'h1FF; i_pwdata = 8'h5A;
    i_pslverr = 1; i_pready = 1;
    tick();
    i_ptransfer = 0;
    check("err_setup_sel2", {31'd0, o_psel2}, 32'd1);
    tick();
    tick();
    check("err_slverr", {31'd0, o_slverr}, 32'd1);
    check("err_prdata_hold", {24'd0, o_prdata}, 32'h3C);
    i_ptransfer = 1; i_pwrite = 0; i_praddr = 9'h000; i_pslverr = 0;
    i_prdata1 = 8'hC3; i_prdata2 = 8'h99;
    tick();
    i_ptransfer = 0;
    check("clr_setup_sel1", {31'd0, o_psel1}, 32'd1);
    check("clr_slverr_hold", {31'd0, o_slverr}, 32'd1);
    tick();
    tick();
    check("clr_slverr", {31'd0, o_slverr}, 32'd0);
    check("clr_prdata", {24'd0, o_prdata}, 32'hC3);

    // Request strobe during ACCESS is ignored
    i_ptransfer = 1; i_pwrite = 0; i_praddr = 9'h0F0; i_pready = 0;
    tick();
    i_ptransfer = 0;
    tick();
    i_ptransfer = 1; i_pwrite = 1; i_pwaddr = 9'h155; i_pwdata = 8'hEE;
    tick();
    check("ign_addr", {23'd0, o_paddr}, 32'h0F0);
    check("ign_pwrite", {31'd0, o_pwrite}, 32'd0);
    check("ign_en", {31'd0, o_penable}, 32'd1);
    i_ptransfer = 0; i_pready = 1; i_prdata1 = 8'h77;
    tick();
    check_idle("ign_done");
    check("ign_prdata", {24'd0, o_prdata}, 32'h77);
    tick();
    check_idle("ign_no_extra");
    check("ign_wdata_hold", {24'd0, o_pwdata}, 32'h5A);

    // Asynchronous reset in the middle of ACCESS
    i_ptransfer = 1; i_pwrite = 1; i_pwaddr = 9'h033; i_pwdata = 8'h44; i_pready = 0;
    tick();
    i_ptransfer = 0;
    tick();
    check("mid_en", {31'd0, o_penable}, 32'd1);
    check("mid_prdata_pre", {24'd0, o_prdata}, 32'h77);
    #2;
    presetn = 1'b0;
    #1;
    check_all_reset("mid_rst");
    tick();
    tick();
    presetn = 1'b1;
    tick();
    check_all_reset("mid_post");

    // Next request completes normally
    i_ptransfer = 1; i_pwrite = 0; i_praddr = 9'h105; i_prdata2 = 8'h5E; i_pready = 1;
    tick();
    i_ptransfer = 0;
    check("nxt_setup_sel2", {31'd0, o_psel2}, 32'd1);
    tick();
    check("nxt_acc_en", {31'd0, o_penable}, 32'd1);
    tick();
    check_idle("nxt_done");
    check("nxt_prdata", {24'd0, o_prdata}, 32'h5E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_apb_master_bridge
`default_nettype wire
